tcm_responder: RTL and testbench
================================

# tcm_responder

Tightly-coupled memory responder for the single-issue RV32I core: serves the core's instruction-fetch port and data load/store port from one shared word array, plus a small MMIO window holding a free-running 64-bit cycle counter and a `tohost` mailbox for simulation end-of-test. Reads are combinational, because the core consumes `i_data` and `d_data` in the same cycle it drives the address. Writes, counter, mailbox and error capture are clocked.

## Interface
Parameters:
- `DEPTH_WORDS`, 1024: number of 32-bit words in the array; power of two, at least 4.
- `MMIO_BASE`, 32'h8000_0000: base of the 16-byte MMIO window; 16-byte aligned.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rstb`  in  1  asynchronous, active-low reset.
- `i_addr`  in  32  fetch byte address.
- `i_data`  out  32  fetched instruction word.
- `d_addr`  in  32  data byte address.
- `d_wr_en`  in  1  store strobe, sampled at the rising edge.
- `d_be`  in  4  store byte-lane mask (bit n = bits [8n+7:8n]).
- `d_wdata`  in  32  store data, lane-aligned to `d_be`.
- `d_data`  out  32  load data, right-justified: word >> (8*`d_addr[1:0]`).
- `tohost_valid`  out  1  one-cycle pulse on a `tohost` write.
- `tohost_data`  out  32  last value written to `tohost`.
- `err`  out  1  sticky error flag.
- `err_code`  out  2  cause of the first error: 1 fetch fault, 2 load fault, 3 store fault.
- `err_addr`  out  32  faulting address of the first error.

## Operation
- Address decode uses byte address A.
  - RAM hit: A[31:2] < `DEPTH_WORDS`; the word index is A[31:2].
  - MMIO hit: A[31:4] == `MMIO_BASE`[31:4]. Offset +0 is `cnt[31:0]`, +4 is `cnt[63:32]`, +8 is `tohost`, +C is reserved (reads 0).
  - Anything else is unmapped.
- Fetch:
  - RAM hit with `i_addr[1:0]`==0: `i_data` = array word.
  - Any other fetch (MMIO, unmapped or misaligned): `i_data` = 32'h0000_0013 (NOP), and a fetch fault is logged.
- Load: `d_data` = selected word >> 8*`d_addr[1:0]`, zero-filled at the top. Unmapped load: `d_data` = 0, and a load fault is logged.
- Load fault logging is gated by an access qualifier. Because the core has no load strobe, load faults are logged only when `d_wr_en`=0 and `d_be` != 0. The core holds `d_be` at the load's lane mask.
- Store, when `d_wr_en`=1 at the edge:
  - `d_be` must be nonzero and must have no set bit below `d_addr[1:0]`. Otherwise the store is dropped and a store fault is logged.
  - RAM: only lanes with `d_be`[n]=1 are updated.
  - `tohost`: `tohost_data` <= `d_wdata`, and `tohost_valid`=1 for the next cycle only.
  - Counter offsets and +C: write ignored, no error.
  - Unmapped: dropped, store fault logged.
- Cycle counter `cnt`: increments by 1 every cycle after reset, wraps 2^64-1 -> 0. The low and high halves are read independently; a 64-bit read is not atomic.
- Error capture: the first fault while `err`=0 sets `err`, `err_code` and `err_addr`. Later faults are ignored until reset. Simultaneous fetch and data faults in one cycle record the data fault.

## Timing
- Read latency is 0 cycles (combinational from address).
- A write takes effect at the edge:
  - A same-cycle read of the written address (either port) returns the old data.
  - The new data is visible from the next cycle.
- `tohost_valid` is asserted the cycle after the accepted write edge. Back-to-back writes give back-to-back pulses.
- Reset values:
  - `tohost_valid`=0, `tohost_data`=0, `err`=0, `err_code`=0, `err_addr`=0, `cnt`=0.
  - Array contents are not reset; they are preloaded by the bench or initialization file.
  - `i_data` and `d_data` follow the array and decode even during reset.
- While `rstb`=0, stores are ignored.
- Reset asserted mid-operation clears `cnt`, the mailbox and the error state immediately (asynchronous). A store on the edge coinciding with reset release is not performed.
- The first counter increment is at the first rising edge with `rstb`=1. A read of `cnt[31:0]` N cycles after release returns N.

## Test plan
- Byte-lane store:
  - Stimulus: preload word 4 = 32'h1122_3344. Store `d_addr`=32'h11, `d_be`=4'b0010, `d_wdata`=32'h0000_AB00.
  - Required response: word 4 = 32'h1122_AB44. A load at 32'h11 returns 32'h0011_22AB.
- Read-during-write:
  - Stimulus: store 32'hDEAD_BEEF to 32'h20 while `i_addr`=32'h20.
  - Required response: `i_data` shows the old word that cycle and 32'hDEAD_BEEF the next.
- Counter:
  - Read +0 at release+5: returns 5.
  - Force `cnt` = 32'hFFFF_FFFF, then one cycle later read +0/+4: returns 0 / 1.
  - Write to +0: ignored, `err`=0.
- Mailbox:
  - Stimulus: stores of 1 then 2 to `MMIO_BASE`+8 on consecutive edges.
  - Required response: `tohost_valid` high for 2 cycles, with `tohost_data` 1 then 2.
- Faults:
  - Store with `d_be`=4'b0001 at `d_addr`=32'h2: dropped, `err_code`=3, `err_addr`=32'h2.
  - A later unmapped fetch leaves the error state unchanged and returns NOP 32'h0000_0013.
- Reset mid-run:
  - Stimulus: assert `rstb` low between edges after `err` is set and `cnt`=100.
  - Required response: `err`, `cnt` and `tohost_valid` clear immediately. RAM contents are retained.

Source files
------------

// File: rtl/tcm_responder.sv
// Shared instruction/data tightly-coupled memory with a 16-byte MMIO window:
// 64-bit cycle counter, tohost mailbox, and first-fault error capture.
module tcm_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic [31:0] i_addr,
  output logic [31:0] i_data,
  input  logic [31:0] d_addr,
  input  logic        d_wr_en,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_data,
  output logic        tohost_valid,
  output logic [31:0] tohost_data,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [31:0] err_addr
);
  localparam int unsigned AW  = $clog2(DEPTH_WORDS);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   r_mem [DEPTH_WORDS];
  logic [63:0]   r_cnt;
  logic [31:0]   r_tohost_data;
  logic          r_tohost_valid;
  logic          r_err;
  logic [1:0]    r_err_code;
  logic [31:0]   r_err_addr;

  logic [AW-1:0] w_i_idx;
  logic [AW-1:0] w_d_idx;
  logic          w_i_ram_hit;
  logic          w_d_ram_hit;
  logic          w_d_mmio_hit;
  logic          w_i_fault;
  logic [31:0]   w_d_word;
  logic [3:0]    w_be_low;
  logic          w_st_ok;
  logic          w_st_fault;
  logic          w_ld_fault;
  logic          w_mem_we;
  logic          w_tohost_we;

  assign w_i_idx      = i_addr[AW+1:2];
  assign w_d_idx      = d_addr[AW+1:2];
  assign w_i_ram_hit  = (i_addr[31:AW+2] == {(30-AW){1'b0}});
  assign w_d_ram_hit  = (d_addr[31:AW+2] == {(30-AW){1'b0}});
  // RAM decode wins should the MMIO window ever overlap the array.
  assign w_d_mmio_hit = !w_d_ram_hit && (d_addr[31:4] == MMIO_BASE[31:4]);

  always_comb begin
    i_data    = NOP;
    w_i_fault = 1'b1;
    if (w_i_ram_hit && (i_addr[1:0] == 2'b00)) begin
      i_data    = r_mem[w_i_idx];
      w_i_fault = 1'b0;
    end else begin
      i_data    = NOP;
      w_i_fault = 1'b1;
    end
  end

  always_comb begin
    w_d_word = 32'h0000_0000;
    if (w_d_ram_hit) begin
      w_d_word = r_mem[w_d_idx];
    end else if (w_d_mmio_hit) begin
      case (d_addr[3:2])
        2'b00:   w_d_word = r_cnt[31:0];
        2'b01:   w_d_word = r_cnt[63:32];
        2'b10:   w_d_word = r_tohost_data;
        default: w_d_word = 32'h0000_0000;
      endcase
    end else begin
      w_d_word = 32'h0000_0000;
    end
  end

  assign d_data = w_d_word >> {d_addr[1:0], 3'b000};

  // Lanes below the byte offset would wrap into the previous word.
  always_comb begin
    case (d_addr[1:0])
      2'b00:   w_be_low = 4'b0000;
      2'b01:   w_be_low = 4'b0001;
      2'b10:   w_be_low = 4'b0011;
      2'b11:   w_be_low = 4'b0111;
      default: w_be_low = 4'b0000;
    endcase
  end

  assign w_st_ok     = (d_be != 4'b0000) && ((d_be & w_be_low) == 4'b0000) &&
                       (w_d_ram_hit || w_d_mmio_hit);
  assign w_st_fault  = d_wr_en && !w_st_ok;
  assign w_ld_fault  = !d_wr_en && (d_be != 4'b0000) && !w_d_ram_hit && !w_d_mmio_hit;
  assign w_mem_we    = rstb && d_wr_en && w_st_ok && w_d_ram_hit;
  assign w_tohost_we = d_wr_en && w_st_ok && w_d_mmio_hit && (d_addr[3:2] == 2'b10);

  always_ff @(posedge clk) begin
    for (int n = 0; n < 4; n++) begin
      if (w_mem_we && d_be[n]) begin
        r_mem[w_d_idx][8*n +: 8] <= d_wdata[8*n +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_cnt          <= 64'd0;
      r_tohost_data  <= 32'h0000_0000;
      r_tohost_valid <= 1'b0;
    end else begin
      r_cnt          <= r_cnt + 64'd1;
      r_tohost_valid <= w_tohost_we;
      if (w_tohost_we) begin
        r_tohost_data <= d_wdata;
      end else begin
        r_tohost_data <= r_tohost_data;
      end
    end
  end

  // Only the first fault is kept; a data fault outranks a same-cycle fetch fault.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_err      <= 1'b0;
      r_err_code <= 2'd0;
      r_err_addr <= 32'h0000_0000;
    end else if (!r_err && (w_st_fault || w_ld_fault)) begin
      r_err      <= 1'b1;
      r_err_code <= w_st_fault ? 2'd3 : 2'd2;
      r_err_addr <= d_addr;
    end else if (!r_err && w_i_fault) begin
      r_err      <= 1'b1;
      r_err_code <= 2'd1;
      r_err_addr <= i_addr;
    end else begin
      r_err      <= r_err;
      r_err_code <= r_err_code;
      r_err_addr <= r_err_addr;
    end
  end

  assign tohost_valid = r_tohost_valid;
  assign tohost_data  = r_tohost_data;
  assign err          = r_err;
  assign err_code     = r_err_code;
  assign err_addr     = r_err_addr;
endmodule

// File: tb/tb_tcm_responder.sv
// Bench for tcm_responder: behavioural memory/MMIO model checked every cycle,
// directed scenarios with literal expectations, then randomized episodes.
module tb_tcm_responder;
  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic [31:0] i_addr = 32'h0;
  logic [31:0] d_addr = 32'h0;
  logic        d_wr_en = 1'b0;
  logic [3:0]  d_be = 4'h0;
  logic [31:0] d_wdata = 32'h0;
  logic [31:0] i_data, d_data, tohost_data, err_addr;
  logic        tohost_valid, err;
  logic [1:0]  err_code;

  tcm_responder #(.DEPTH_WORDS(DEPTH), .MMIO_BASE(BASE)) dut (
    .clk(clk), .rstb(rstb), .i_addr(i_addr), .i_data(i_data),
    .d_addr(d_addr), .d_wr_en(d_wr_en), .d_be(d_be), .d_wdata(d_wdata),
    .d_data(d_data), .tohost_valid(tohost_valid), .tohost_data(tohost_data),
    .err(err), .err_code(err_code), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  logic [31:0] m_mem [DEPTH];
  logic [63:0] m_cnt = 64'd0;
  logic [31:0] m_thd = 32'h0;
  logic        m_thv = 1'b0;
  logic        m_err = 1'b0;
  logic [1:0]  m_code = 2'd0;
  logic [31:0] m_eaddr = 32'h0;
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          chk_en = 1'b0;
  bit          f_fetch, f_load, f_store, st_ok;

  function automatic bit ram_hit(input logic [31:0] a);
    return (a / 4) < DEPTH;
  endfunction

  function automatic bit mmio_hit(input logic [31:0] a);
    return !ram_hit(a) && ((a / 16) == (BASE / 16));
  endfunction

  function automatic logic [31:0] exp_i(input logic [31:0] a);
    if (ram_hit(a) && (a % 4) == 0) return m_mem[a / 4];
    return 32'h0000_0013;
  endfunction

  function automatic logic [31:0] exp_d(input logic [31:0] a);
    logic [31:0] w;
    w = 32'h0;
    if (ram_hit(a)) w = m_mem[a / 4];
    else if (mmio_hit(a)) begin
      case ((a / 4) % 4)
        0:       w = m_cnt[31:0];
        1:       w = m_cnt[63:32];
        2:       w = m_thd;
        default: w = 32'h0;
      endcase
    end
    return w >> (8 * (a % 4));
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: spec rules applied at each rising edge.
  always @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      m_cnt = 64'd0; m_thd = 32'h0; m_thv = 1'b0;
      m_err = 1'b0; m_code = 2'd0; m_eaddr = 32'h0;
    end else begin
      f_fetch = !(ram_hit(i_addr) && (i_addr % 4) == 0);
      f_load  = !d_wr_en && d_be != 4'h0 && !ram_hit(d_addr) && !mmio_hit(d_addr);
      st_ok   = d_be != 4'h0 && (int'(d_be) % (1 << (d_addr % 4))) == 0 &&
                (ram_hit(d_addr) || mmio_hit(d_addr));
      f_store = d_wr_en && !st_ok;
      if (!m_err) begin
        if (f_load || f_store) begin
          m_err = 1'b1; m_code = f_store ? 2'd3 : 2'd2; m_eaddr = d_addr;
        end else if (f_fetch) begin
          m_err = 1'b1; m_code = 2'd1; m_eaddr = i_addr;
        end
      end
      m_thv = 1'b0;
      if (d_wr_en && st_ok) begin
        if (ram_hit(d_addr)) begin
          for (int n = 0; n < 4; n++)
            if (d_be[n]) m_mem[d_addr / 4][8*n +: 8] = d_wdata[8*n +: 8];
        end else if ((d_addr / 4) % 4 == 2) begin
          m_thd = d_wdata; m_thv = 1'b1;
        end
      end
      m_cnt = m_cnt + 64'd1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("i_data", i_data, exp_i(i_addr));
      chk("d_data", d_data, exp_d(d_addr));
      chk("tohost_valid", tohost_valid, m_thv);
      chk("tohost_data", tohost_data, m_thd);
      chk("err", err, m_err);
      chk("err_code", err_code, m_code);
      chk("err_addr", err_addr, m_eaddr);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    d_wr_en = 1'b0;
    d_be    = 4'h0;
  endtask

  task automatic store(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
    d_addr = a; d_be = be; d_wdata = wd; d_wr_en = 1'b1;
  endtask

  logic [31:0] old_w;
  int          r;
  int          off;
  int          guard;

  initial begin
    // Preload the whole array through the store port.
    step(); step();
    rstb = 1'b1;
    for (int w = 0; w < DEPTH; w++) begin
      store(w * 4, 4'hF, $urandom);
      step();
    end
    idle();
    d_addr = 32'h0;
    chk_en = 1'b1;

    rstb = 1'b0;
    d_addr = BASE;
    #1;
    chk("rst_cnt", d_data, 32'd0);
    chk("rst_err", err, 1'b0);
    chk("rst_err_code", err_code, 2'd0);
    chk("rst_err_addr", err_addr, 32'd0);
    chk("rst_tohost_valid", tohost_valid, 1'b0);
    chk("rst_tohost_data", tohost_data, 32'd0);
    step();
    old_w = m_mem[12];
    store(32'h30, 4'hF, 32'h5A5A_5A5A);
    step();
    idle();
    d_addr = 32'h30;
    #1;
    chk("store_in_reset_ignored", d_data, old_w);
    step();

    rstb = 1'b1;
    d_addr = BASE;
    repeat (5) step();
    #1;
    chk("cnt_release_plus5", d_data, 32'd5);
    step();

    store(32'h10, 4'hF, 32'h1122_3344);
    step();
    store(32'h11, 4'b0010, 32'h0000_AB00);
    step();
    idle();
    d_addr = 32'h10;
    #1;
    chk("byte_lane_word", d_data, 32'h1122_AB44);
    d_addr = 32'h11;
    #1;
    chk("byte_lane_load", d_data, 32'h0011_22AB);
    step();

    old_w = m_mem[8];
    i_addr = 32'h20;
    store(32'h20, 4'hF, 32'hDEAD_BEEF);
    #1;
    chk("rdw_old_fetch", i_data, old_w);
    step();
    idle();
    #1;
    chk("rdw_new_fetch", i_data, 32'hDEAD_BEEF);
    step();
    i_addr = 32'h0;

    force dut.r_cnt = 64'h0000_0000_FFFF_FFFF;
    m_cnt = 64'h0000_0000_FFFF_FFFF;
    #1;
    release dut.r_cnt;
    step();
    d_addr = BASE;
    #1;
    chk("cnt_wrap_lo", d_data, 32'd0);
    d_addr = BASE + 32'd4;
    #1;
    chk("cnt_wrap_hi", d_data, 32'd1);
    step();

    store(BASE, 4'hF, 32'h0001_2345);
    step();
    idle();
    #1;
    chk("cnt_write_no_err", err, 1'b0);
    step();

    store(BASE + 32'd8, 4'hF, 32'd1);
    step();
    store(BASE + 32'd8, 4'hF, 32'd2);
    #1;
    chk("mbox_valid_1", tohost_valid, 1'b1);
    chk("mbox_data_1", tohost_data, 32'd1);
    step();
    idle();
    #1;
    chk("mbox_valid_2", tohost_valid, 1'b1);
    chk("mbox_data_2", tohost_data, 32'd2);
    step();
    #1;
    chk("mbox_valid_end", tohost_valid, 1'b0);
    step();

    store(32'h2, 4'b0001, 32'hFFFF_FFFF);
    step();
    idle();
    i_addr = 32'h0000_FFF0;
    #1;
    chk("st_fault_err", err, 1'b1);
    chk("st_fault_code", err_code, 2'd3);
    chk("st_fault_addr", err_addr, 32'h2);
    chk("unmapped_fetch_nop", i_data, 32'h0000_0013);
    step();
    i_addr = 32'h0;
    #1;
    chk("err_code_held", err_code, 2'd3);
    chk("err_addr_held", err_addr, 32'h2);
    step();

    // Reset mid-run with err set, cnt at 100 and a mailbox pulse live.
    rstb = 1'b0;
    step();
    rstb = 1'b1;
    store(32'h40, 4'h0, 32'h0);
    step();
    idle();
    guard = 0;
    while (m_cnt != 64'd99 && guard < 200) begin
      step();
      guard++;
    end
    chk("cnt_reach_99", m_cnt, 64'd99);
    store(BASE + 32'd8, 4'hF, 32'd77);
    step();
    idle();
    d_addr = BASE;
    #1;
    chk("pre_rst_cnt", d_data, 32'd100);
    chk("pre_rst_err", err, 1'b1);
    chk("pre_rst_valid", tohost_valid, 1'b1);
    rstb = 1'b0;
    #1;
    chk("midrst_cnt", d_data, 32'd0);
    chk("midrst_err", err, 1'b0);
    chk("midrst_valid", tohost_valid, 1'b0);
    step();
    d_addr = 32'h10;
    #1;
    chk("midrst_ram_kept", d_data, 32'h1122_AB44);
    step();

    for (int ep = 0; ep < 20; ep++) begin
      idle();
      rstb = 1'b0;
      step();
      rstb = 1'b1;
      for (int c = 0; c < 60; c++) begin
        r = $urandom_range(0, 19);
        if (r < 17)       i_addr = $urandom_range(0, DEPTH - 1) * 4;
        else if (r == 17) i_addr = BASE + $urandom_range(0, 15);
        else if (r == 18) i_addr = $urandom_range(0, DEPTH * 4 - 1);
        else              i_addr = $urandom;
        r = $urandom_range(0, 19);
        if (r < 14)      d_addr = $urandom_range(0, DEPTH * 4 - 1);
        else if (r < 19) d_addr = BASE + $urandom_range(0, 15);
        else             d_addr = $urandom;
        d_wr_en = ($urandom_range(0, 2) == 0);
        d_wdata = $urandom;
        off = int'(d_addr[1:0]);
        if ($urandom_range(0, 9) < 9) begin
          d_be = 4'((int'($urandom_range(1, 15)) << off) & 15);
          if (d_be == 4'h0) d_be = 4'b1000;
        end else begin
          d_be = 4'($urandom_range(0, 15));
        end
        step();
      end
    end
    idle();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
